// File: rtl/sram_read_arbiter_if.sv
// Read-port bundle between the Q/T parsers, the sequence SRAM and the read arbiter.
// The arbiter connects through the slave modport; the parser/SRAM side uses master.
interface sram_read_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 30
);
  logic              flush_i;
  logic              q_request_i;
  logic [ADDR_W-1:0] q_addr_i;
  logic [DATA_W-1:0] q_data_o;
  logic              q_valid_o;
  logic              t_request_i;
  logic [ADDR_W-1:0] t_addr_i;
  logic [DATA_W-1:0] t_data_o;
  logic              t_valid_o;
  logic              sram_cen_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_data_i;
  logic              busy_o;

  modport slave (
    input  flush_i, q_request_i, q_addr_i, t_request_i, t_addr_i, sram_data_i,
    output q_data_o, q_valid_o, t_data_o, t_valid_o, sram_cen_o, sram_addr_o, busy_o
  );

  modport master (
    output flush_i, q_request_i, q_addr_i, t_request_i, t_addr_i, sram_data_i,
    input  q_data_o, q_valid_o, t_data_o, t_valid_o, sram_cen_o, sram_addr_o, busy_o
  );
endinterface

// File: rtl/sram_read_arbiter.sv
// Round-robin sharing of the sequence SRAM read port between the query (Q) and target (T)
// parsers; a tag pipeline aligned to the SRAM latency routes each word back to its owner.
module sram_read_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 30,
  parameter int unsigned RD_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  sram_read_arbiter_if.slave bus
);

  localparam int unsigned N_STAGES = RD_LAT + 1;

  typedef enum logic {
    OWNER_Q = 1'b0,
    OWNER_T = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e id;
  } tag_t;

  logic   pending_q;
  logic   pending_t;
  owner_e last_grant;
  tag_t   tag_pipe [N_STAGES];

  logic elig_q_c;
  logic elig_t_c;
  logic grant_q_c;
  logic grant_t_c;
  logic grant_c;
  logic ret_q_c;
  logic ret_t_c;
  logic pending_q_nxt_c;
  logic pending_t_nxt_c;

  // Arbitration, return routing and next pending state.
  always_comb begin
    elig_q_c  = bus.q_request_i & ~pending_q & ~bus.flush_i;
    elig_t_c  = bus.t_request_i & ~pending_t & ~bus.flush_i;
    // On a tie the requester that did not win last time goes first.
    grant_q_c = elig_q_c & (~elig_t_c | (last_grant == OWNER_T));
    grant_t_c = elig_t_c & (~elig_q_c | (last_grant == OWNER_Q));
    grant_c   = grant_q_c | grant_t_c;

    ret_q_c   = tag_pipe[RD_LAT].valid & (tag_pipe[RD_LAT].id == OWNER_Q) & ~bus.flush_i;
    ret_t_c   = tag_pipe[RD_LAT].valid & (tag_pipe[RD_LAT].id == OWNER_T) & ~bus.flush_i;

    // Pending stays set through the valid cycle so a held request is not re-granted.
    pending_q_nxt_c = ~bus.flush_i & (grant_q_c | (pending_q & ~bus.q_valid_o));
    pending_t_nxt_c = ~bus.flush_i & (grant_t_c | (pending_t & ~bus.t_valid_o));
  end

  // Grant bookkeeping and SRAM command.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q       <= 1'b0;
      pending_t       <= 1'b0;
      last_grant      <= OWNER_T;
      bus.sram_cen_o  <= 1'b0;
      bus.sram_addr_o <= '0;
      bus.busy_o      <= 1'b0;
    end else begin
      pending_q      <= pending_q_nxt_c;
      pending_t      <= pending_t_nxt_c;
      bus.busy_o     <= pending_q_nxt_c | pending_t_nxt_c;
      bus.sram_cen_o <= grant_c;
      if (grant_q_c) begin
        bus.sram_addr_o <= ADDR_W'(bus.q_addr_i);
        last_grant      <= OWNER_Q;
      end else if (grant_t_c) begin
        bus.sram_addr_o <= ADDR_W'(bus.t_addr_i);
        last_grant      <= OWNER_T;
      end
    end
  end

  // Tag pipeline: the final stage lines up with the SRAM data of the same read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_STAGES; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: grant_c, id: (grant_t_c ? OWNER_T : OWNER_Q)};
      for (int unsigned i = 1; i < N_STAGES; i++) begin
        tag_pipe[i] <= bus.flush_i ? '0 : tag_pipe[i-1];
      end
    end
  end

  // Return path: capture the word for its owner only and pulse that owner's valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.q_data_o  <= '0;
      bus.q_valid_o <= 1'b0;
      bus.t_data_o  <= '0;
      bus.t_valid_o <= 1'b0;
    end else begin
      bus.q_valid_o <= ret_q_c;
      bus.t_valid_o <= ret_t_c;
      if (ret_q_c) begin
        bus.q_data_o <= DATA_W'(bus.sram_data_i);
      end
      if (ret_t_c) begin
        bus.t_data_o <= DATA_W'(bus.sram_data_i);
      end
    end
  end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: cycle table on an RD_LAT=1 instance, plus fairness
// and reset-during-read sequences on RD_LAT=1 and RD_LAT=3 instances.
module tb_sram_read_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 30;

  localparam int unsigned MEM3  = 32'h1111_1111;
  localparam int unsigned MEM5  = 32'h2AAA_AAAA;
  localparam int unsigned MEM7  = 32'h0765_4321;
  localparam int unsigned MEM9  = 32'h3FFF_FFFF;
  localparam int unsigned MEM11 = 32'h2BAD_BEEF;
  localparam int unsigned MEM20 = 32'h0101_0101;
  localparam int unsigned MEM21 = 32'h15A5_A5A5;
  localparam int unsigned MEM100 = 32'h0ABC_DEF0;
  localparam int unsigned MEM600 = 32'h3C3C_3C3C;

  typedef struct {
    int unsigned rst, flush, q_req, q_addr, t_req, t_addr, chk;
    int unsigned cen, addr, qv, qd, tv, td, busy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst2;
  int   compared   = 0;
  int   mismatched = 0;

  sram_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  sram_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  sram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1)
  );
  sram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  // SRAM models: data appears RD_LAT cycles after the cycle in which cen is high.
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] s1_p0;
  logic [DATA_W-1:0] s2_p0, s2_p1, s2_p2;

  always_ff @(posedge clk) begin
    if (bus1.sram_cen_o) s1_p0 <= mem[bus1.sram_addr_o];
    if (bus2.sram_cen_o) s2_p0 <= mem[bus2.sram_addr_o];
    s2_p1 <= s2_p0;
    s2_p2 <= s2_p1;
  end
  assign bus1.sram_data_i = s1_p0;
  assign bus2.sram_data_i = s2_p2;

  task automatic check(input string name, input int row, input int unsigned act,
                       input int unsigned exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (step %0d): got %h, want %h", name, row, act, exp);
    end
  endtask

  function automatic vec_t v(int unsigned rst, int unsigned flush, int unsigned qr,
                             int unsigned qa, int unsigned tr, int unsigned ta,
                             int unsigned chk, int unsigned cen, int unsigned addr,
                             int unsigned qv, int unsigned qd, int unsigned tv,
                             int unsigned td, int unsigned busy);
    vec_t r;
    r.rst = rst; r.flush = flush; r.q_req = qr; r.q_addr = qa; r.t_req = tr; r.t_addr = ta;
    r.chk = chk; r.cen = cen; r.addr = addr; r.qv = qv; r.qd = qd; r.tv = tv; r.td = td;
    r.busy = busy;
    return r;
  endfunction

  // A grant must never fire for a requester that already has a read outstanding.
  always @(negedge clk) begin
    if ((dut1.grant_q_c && dut1.pending_q) || (dut1.grant_t_c && dut1.pending_t) ||
        (dut2.grant_q_c && dut2.pending_q) || (dut2.grant_t_c && dut2.pending_t)) begin
      mismatched++;
      $display("FAIL grant_while_pending at %0t", $time);
    end
  end

  // Fairness monitor on instance 1: grant counts, outstanding reads and returned data.
  logic mon_en = 1'b0;
  int   gq = 0, gt = 0, out_q = 0, out_t = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus1.q_valid_o) begin
        out_q--;
        check("fair_q_data", gq, 32'(bus1.q_data_o), MEM100);
      end
      if (bus1.t_valid_o) begin
        out_t--;
        check("fair_t_data", gt, 32'(bus1.t_data_o), MEM600);
      end
      if (bus1.sram_cen_o) begin
        if (bus1.sram_addr_o == ADDR_W'(100)) begin
          gq++; out_q++;
          if (out_q > 1) begin
            mismatched++;
            $display("FAIL fair_q_outstanding: got %0d, want <= 1", out_q);
          end
        end else begin
          gt++; out_t++;
          if (out_t > 1) begin
            mismatched++;
            $display("FAIL fair_t_outstanding: got %0d, want <= 1", out_t);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs[$];
  int   cen_cnt;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i * 32'h0009_3A5B);
    mem[3] = DATA_W'(MEM3);   mem[5] = DATA_W'(MEM5);   mem[7] = DATA_W'(MEM7);
    mem[9] = DATA_W'(MEM9);   mem[11] = DATA_W'(MEM11); mem[20] = DATA_W'(MEM20);
    mem[21] = DATA_W'(MEM21); mem[100] = DATA_W'(MEM100); mem[600] = DATA_W'(MEM600);

    rst1 = 1'b1; rst2 = 1'b1;
    bus1.flush_i = 1'b0; bus1.q_request_i = 1'b0; bus1.q_addr_i = '0;
    bus1.t_request_i = 1'b0; bus1.t_addr_i = '0;
    bus2.flush_i = 1'b0; bus2.q_request_i = 1'b0; bus2.q_addr_i = '0;
    bus2.t_request_i = 1'b0; bus2.t_addr_i = '0;

    //          rst fl qr qa tr ta chk cen addr qv qd     tv td     busy
    // Single Q read, request held through the valid cycle.
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 1, 5, 0, 0, 1,  0, 0,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 1, 5, 0, 0, 1,  1, 5,  0, 0,     0, 0,     1));
    vecs.push_back(v(0, 0, 1, 5, 0, 0, 1,  0, 5,  0, 0,     0, 0,     1));
    vecs.push_back(v(0, 0, 1, 5, 0, 0, 1,  0, 5,  1, MEM5,  0, 0,     1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 5,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 5,  0, 0,     0, 0,     0));
    // Tie after reset: Q first, then T.
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 1, 3, 1, 7, 1,  0, 0,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 1, 3, 1, 7, 1,  1, 3,  0, 0,     0, 0,     1));
    vecs.push_back(v(0, 0, 1, 3, 1, 7, 1,  1, 7,  0, 0,     0, 0,     1));
    vecs.push_back(v(0, 0, 1, 3, 1, 7, 1,  0, 7,  1, MEM3,  0, 0,     1));
    vecs.push_back(v(0, 0, 0, 0, 1, 7, 1,  0, 7,  0, 0,     1, MEM7,  1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 7,  0, 0,     0, 0,     0));
    // Flush one cycle after a T grant, then a clean T read.
    vecs.push_back(v(0, 0, 0, 0, 1, 9, 1,  0, 7,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 1, 0, 0, 1, 9, 1,  1, 9,  0, 0,     0, 0,     1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 9,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 9,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 0, 0, 1, 11, 1, 0, 9,  0, 0,     0, 0,     0));
    vecs.push_back(v(0, 0, 0, 0, 1, 11, 1, 1, 11, 0, 0,     0, 0,     1));
    vecs.push_back(v(0, 0, 0, 0, 1, 11, 1, 0, 11, 0, 0,     0, 0,     1));
    vecs.push_back(v(0, 0, 0, 0, 1, 11, 1, 0, 11, 0, 0,     1, MEM11, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,  0, 11, 0, 0,     0, 0,     0));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst1 = (vecs[i].rst != 0);
      bus1.flush_i = (vecs[i].flush != 0);
      bus1.q_request_i = (vecs[i].q_req != 0);
      bus1.q_addr_i = ADDR_W'(vecs[i].q_addr);
      bus1.t_request_i = (vecs[i].t_req != 0);
      bus1.t_addr_i = ADDR_W'(vecs[i].t_addr);
      @(negedge clk);
      if (vecs[i].chk != 0) begin
        check("cen",  i, 32'(bus1.sram_cen_o),  vecs[i].cen);
        check("addr", i, 32'(bus1.sram_addr_o), vecs[i].addr);
        check("q_valid", i, 32'(bus1.q_valid_o), vecs[i].qv);
        check("t_valid", i, 32'(bus1.t_valid_o), vecs[i].tv);
        check("busy", i, 32'(bus1.busy_o), vecs[i].busy);
        if (vecs[i].qv != 0) check("q_data", i, 32'(bus1.q_data_o), vecs[i].qd);
        if (vecs[i].tv != 0) check("t_data", i, 32'(bus1.t_data_o), vecs[i].td);
      end
    end

    // Fairness: both requesters keep requesting for 40 cycles.
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    mon_en = 1'b1;
    bus1.q_request_i = 1'b1; bus1.q_addr_i = ADDR_W'(100);
    bus1.t_request_i = 1'b1; bus1.t_addr_i = ADDR_W'(600);
    repeat (40) @(posedge clk);
    #1;
    bus1.q_request_i = 1'b0; bus1.t_request_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("fair_q_grants", 0, 32'(gq), 10);
    check("fair_t_grants", 0, 32'(gt), 10);
    check("fair_balance", 0, 32'((gq - gt <= 1) && (gt - gq <= 1)), 1);
    check("fair_q_drained", 0, 32'(out_q), 0);
    check("fair_t_drained", 0, 32'(out_t), 0);

    // RD_LAT=3: reset while a Q read is in flight.
    @(posedge clk); #1;
    rst2 = 1'b0;
    bus2.q_request_i = 1'b1; bus2.q_addr_i = ADDR_W'(20);
    @(negedge clk);
    check("l3_reset_cen",  0, 32'(bus2.sram_cen_o), 0);
    check("l3_reset_busy", 0, 32'(bus2.busy_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("l3_first_cen",  1, 32'(bus2.sram_cen_o), 1);
    check("l3_first_addr", 1, 32'(bus2.sram_addr_o), 20);
    @(posedge clk); #1;
    rst2 = 1'b1; bus2.q_request_i = 1'b0;
    @(negedge clk);
    check("l3_busy_before_rst", 2, 32'(bus2.busy_o), 1);
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(negedge clk);
    check("l3_rst_cen",    3, 32'(bus2.sram_cen_o), 0);
    check("l3_rst_addr",   3, 32'(bus2.sram_addr_o), 0);
    check("l3_rst_qdata",  3, 32'(bus2.q_data_o), 0);
    check("l3_rst_tdata",  3, 32'(bus2.t_data_o), 0);
    check("l3_rst_tvalid", 3, 32'(bus2.t_valid_o), 0);
    check("l3_rst_busy",   3, 32'(bus2.busy_o), 0);
    for (int c = 3; c <= 8; c++) begin
      if (c > 3) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      check("l3_no_stale_qvalid", c, 32'(bus2.q_valid_o), 0);
    end

    // Fresh Q read: valid exactly RD_LAT+2 = 5 cycles after the request.
    @(posedge clk); #1;
    bus2.q_request_i = 1'b1; bus2.q_addr_i = ADDR_W'(21);
    cen_cnt = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 6) bus2.q_request_i = 1'b0;
      end
      @(negedge clk);
      if (bus2.sram_cen_o) cen_cnt++;
      check("l3_q_valid", c, 32'(bus2.q_valid_o), (c == 5) ? 1 : 0);
      if (c == 5) check("l3_q_data", c, 32'(bus2.q_data_o), MEM21);
    end
    check("l3_busy_after", 6, 32'(bus2.busy_o), 0);
    check("l3_cen_pulses", 6, 32'(cen_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_read_arbiter.md
Name: sram_read_arbiter

Overview:
- Shares the single read port of the sequence SRAM between the query parser (Q) and the target parser (T).
- Each parser keeps its existing level request/addr handshake and receives a one-cycle data valid pulse.
- The block arbitrates round-robin, issues registered SRAM reads, and tracks in-flight reads with a tag pipeline.
- Each returned word is routed to its owner only.

Parameters:
ADDR_W, 10, SRAM address width
DATA_W, 30, SRAM word width (10 DNA symbols x 3 bits)
RD_LAT, 1, SRAM read latency in cycles from cen to valid data (1..4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flush_i  in  1  abort all outstanding reads
q_request_i  in  1  Q read request, level, held until q_valid_o seen
q_addr_i  in  ADDR_W  Q read address, stable while q_request_i high
q_data_o  out  DATA_W  read data to Q
q_valid_o  out  1  one-cycle pulse, q_data_o valid
t_request_i  in  1  T read request, same protocol as Q
t_addr_i  in  ADDR_W  T read address
t_data_o  out  DATA_W  read data to T
t_valid_o  out  1  one-cycle pulse, t_data_o valid
sram_cen_o  out  1  SRAM read enable (active high)
sram_addr_o  out  ADDR_W  SRAM read address
sram_data_i  in  DATA_W  SRAM read data, valid RD_LAT cycles after cen
busy_o  out  1  any read granted and not yet returned or flushed

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs go to 0: data outputs, valid pulses, sram_cen_o, sram_addr_o and busy_o.
  - pending_q and pending_t are cleared, and the tag pipeline is cleared.
  - last_grant is set to T, so Q wins the first tie.
  - Reset mid-read drops the read silently. No valid is produced for it afterwards.
- Eligibility: eligible_x = x_request_i & ~pending_x & ~flush_i.
- Arbitration happens combinationally in cycle N, with at most one grant per cycle:
  - Only one requester eligible: that requester wins.
  - Both eligible: the requester other than last_grant wins.
- Grant effects at the end of cycle N:
  - sram_cen_o is set to 1 and sram_addr_o to the winner's address.
  - pending_winner is set and last_grant is updated.
  - Tag {valid=1, id=winner} is pushed into stage 0.
- With no grant, sram_cen_o is 0 and sram_addr_o holds its last value.
- Tag pipeline: RD_LAT+1 stages shifting every cycle. The tag reaching the final stage lines up with sram_data_i for that read (cycle N+1+RD_LAT).
- Return:
  - In cycle N+1+RD_LAT, a valid final-stage tag registers sram_data_i into the owner's data_o.
  - The owner's valid_o pulses 1 in cycle N+2+RD_LAT.
  - The owner's pending bit clears on that same edge.
- Latency: request first sampled in cycle N, valid_o in cycle N+2+RD_LAT (N+3 for RD_LAT=1).
- Non-owner data_o holds its previous value. A valid pulse lasts exactly one cycle.
- A parser still holds request high in the cycle its valid_o is high. pending_x is still 1 in that cycle, so no re-grant occurs.
  - A fresh request from the next cycle onward is eligible normally.
- Address sampling: addresses are sampled only on the grant edge. Address changes while pending are ignored.
- Flush: flush_i=1 at an edge clears both pending bits and all tag valid bits, and produces no grant that cycle.
  - Any data arriving later for flushed reads is discarded, with no valid_o.
  - A valid_o already registered (high in the flush cycle) is not retracted.
- Simultaneous return and new grant for different requesters is allowed. The pipeline handles one issue and one return per cycle.
- Throughput:
  - Both requesters continuously requesting get alternating grants, one per cycle while each is not pending.
  - A single requester gets one read every RD_LAT+3 cycles, limited by its own handshake.
- busy_o (registered) is 1 when any pending bit is set, else 0.
- The implementation asserts that no pending bit is set while its own grant fires. This is a bench assertion; it must never fire.

Test Plan:
- Reset then single read: q_request_i=1, q_addr_i=5 at cycle 0, RD_LAT=1, memory[5]=0x2AAAAAAA.
  - Required: sram_cen_o=1 with addr 5 in cycle 1, q_valid_o=1 with q_data_o=0x2AAAAAAA in cycle 3.
  - Required: t_valid_o stays 0 throughout.
- Tie: both requests rise in cycle 0 (Q addr 3, T addr 7).
  - Required: Q is granted in cycle 0 and T in cycle 1; sram_addr_o=3 in cycle 1 and 7 in cycle 2.
  - Required: q_valid_o in cycle 3, t_valid_o in cycle 4, each carrying its own word.
- Round-robin fairness: both hold requests and re-request immediately after each valid for 40 cycles.
  - Required: grant counts differ by at most 1, and no requester ever has two reads outstanding.
- Request held through valid: Q keeps request high in its valid cycle and drops it on the next edge.
  - Required: exactly one sram_cen_o pulse and one q_valid_o pulse.
- Flush: grant T, assert flush_i one cycle later.
  - Required: t_valid_o never rises and busy_o=0 after the flush edge.
  - Required: a new T request afterwards completes normally with correct data.
- Reset mid-operation and RD_LAT=3: rst pulsed while a Q read is in flight.
  - Required: all outputs read 0 after the reset edge and no stale q_valid_o appears.
  - Required: a following Q read returns valid 5 cycles after its request.
